// File: rtl/inst_mem_fetch.sv
// Instruction memory with a valid/ready fetch port and a program-load write port.
// Fetches return one cycle after acceptance through a single-entry output stage that
// honours consumer back-pressure and pipeline flush. Writes occur at the clock edge.
// When a write and a read hit the same word in one cycle, the read returns the old word.
// Optional feature macro: INSTMEM_ERR_CHECK_EN. When it is defined, a misaligned or
// out-of-range fetch returns NOP_WORD with rsp_err=1.
module inst_mem_fetch #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DEPTH    = 256,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_inst,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned   IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  state_t            r_state;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_inst;
  logic [ADDR_W-1:0] r_rsp_addr;
  logic              r_rsp_err;

  logic              w_req_ready;
  logic              w_accept;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_wr_ok;
  logic              w_rd_err;
  logic [DATA_W-1:0] w_rd_data;

  // Handshake: ready while the output slot is free or being drained; never in reset.
  assign w_req_ready = rst & (~r_rsp_valid | rsp_ready);
  assign w_accept    = req_valid & w_req_ready & ~flush;

  assign w_rd_idx = req_addr[2 +: IDX_W];
  assign w_wr_idx = wr_addr[2 +: IDX_W];

  // Program-load writes only land on aligned, in-range word addresses.
  assign w_wr_ok = wr_en & (wr_addr[1:0] == 2'b00) & ({1'b0, wr_addr} < LIMIT);

`ifdef INSTMEM_ERR_CHECK_EN
  assign w_rd_err = (req_addr[1:0] != 2'b00) | ({1'b0, req_addr} < LIMIT ? 1'b0 : 1'b1);
`else
  // Without error checking the byte offset and upper address bits are don't-care.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr;
  assign w_rd_err      = 1'b0;
`endif

  assign w_rd_data = w_rd_err ? NOP_WORD : r_mem[w_rd_idx];

  // Memory array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_idx] <= wr_data;
    end
  end

  // Output-stage FSM: flush empties, accept loads, drain empties.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_EMPTY;
      r_rsp_valid <= 1'b0;
      r_rsp_inst  <= NOP_WORD;
      r_rsp_addr  <= '0;
      r_rsp_err   <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_rsp_valid <= 1'b0;
    end else if (w_accept) begin
      r_state     <= ST_FULL;
      r_rsp_valid <= 1'b1;
      r_rsp_inst  <= w_rd_data;
      r_rsp_addr  <= req_addr;
      r_rsp_err   <= w_rd_err;
    end else begin
      case (r_state)
        ST_FULL: begin
          if (rsp_ready) begin
            r_state     <= ST_EMPTY;
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_inst  = r_rsp_inst;
  assign rsp_addr  = r_rsp_addr;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_inst_mem_fetch.sv
// Bench for inst_mem_fetch: directed vectors with literal expectations, plus a
// behavioural model compared against the DUT on every falling edge after reset.
module tb_inst_mem_fetch;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        flush;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_inst;
  logic [31:0] rsp_addr;
  logic        rsp_err;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  int n_vec = 0;
  int n_err = 0;

  inst_mem_fetch #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst),
    .rsp_addr(rsp_addr), .rsp_err(rsp_err),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_live = 0;
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_addr;
  bit          m_err;

  function automatic bit bad_fetch(input logic [31:0] a);
`ifdef INSTMEM_ERR_CHECK_EN
    return (a % 4 != 0) || (a >= DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit can_take;
    can_take = !m_valid || rsp_ready;
    if (!rst) begin
      m_live = 1; m_valid = 0; m_inst = 0; m_addr = 0; m_err = 0;
    end else if (flush) begin
      m_valid = 0;
    end else if (req_valid && can_take) begin
      m_valid = 1;
      m_addr  = req_addr;
      m_err   = bad_fetch(req_addr);
      m_inst  = m_err ? 32'h0 : m_mem[(req_addr / 4) % DEPTH];
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    // Write applied after the read above: the response sees the old word.
    if (wr_en && (wr_addr % 4 == 0) && (wr_addr < DEPTH * 4))
      m_mem[wr_addr / 4] = wr_data;
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("model_req_ready", 32'(req_ready), 32'(rst && (!m_valid || rsp_ready)));
      if (m_valid) begin
        chk("model_rsp_inst", rsp_inst, m_inst);
        chk("model_rsp_addr", rsp_addr, m_addr);
        chk("model_rsp_err",  32'(rsp_err), 32'(m_err));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp_inst,
                       input bit exp_err, input string nm);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    cyc();
    chk({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, "_inst"},  rsp_inst, exp_inst);
    chk({nm, "_addr"},  rsp_addr, a);
    chk({nm, "_err"},   32'(rsp_err), 32'(exp_err));
    req_valid = 1'b0;
    cyc();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0; rsp_ready = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset held two cycles.
    cyc(); cyc();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_inst",  rsp_inst, 32'h0);
    chk("reset_rsp_addr",  rsp_addr, 32'h0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("release_req_ready", 32'(req_ready), 32'd1);
    cyc();

    // Preload every word so no fetch ever sees an unwritten location.
    for (int i = 0; i < int'(DEPTH); i++) wr(32'(i * 4), 32'h1000_0000 | 32'(i));

    // Back-to-back fetches of freshly written words.
    wr(32'h0, 32'h0022_1000);
    wr(32'h4, 32'h0064_1000);
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    cyc();
    chk("b2b0_inst", rsp_inst, 32'h0022_1000);
    chk("b2b0_addr", rsp_addr, 32'h0);
    req_addr = 32'h4;
    cyc();
    chk("b2b1_inst", rsp_inst, 32'h0064_1000);
    chk("b2b1_addr", rsp_addr, 32'h4);
    req_valid = 1'b0;
    cyc();

    // Back-pressure: response holds, no new accept, then same-cycle accept on release.
    req_valid = 1'b1; req_addr = 32'h8; rsp_ready = 1'b0;
    cyc();
    req_addr = 32'hC;
    for (int k = 0; k < 3; k++) begin
      chk("bp_inst",  rsp_inst, 32'h1000_0002);
      chk("bp_addr",  rsp_addr, 32'h8);
      chk("bp_ready", 32'(req_ready), 32'd0);
      if (k < 2) cyc();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    cyc();
    chk("bp_next_inst", rsp_inst, 32'h1000_0003);
    chk("bp_next_addr", rsp_addr, 32'hC);

    // Flush while full with a concurrent request to 12.
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'hC; rsp_ready = 1'b0;
    cyc();
    chk("flush_valid", 32'(rsp_valid), 32'd0);
    flush = 1'b0; req_valid = 1'b0;
    cyc();
    chk("flush_after_valid", 32'(rsp_valid), 32'd0);

    // Read-first on same-cycle write/read of one word.
    wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_addr = 32'h10; rsp_ready = 1'b1;
    cyc();
    chk("rfirst_old", rsp_inst, 32'h1000_0004);
    wr_en = 1'b0; req_valid = 1'b0;
    cyc();
    fetch(32'h10, 32'hDEAD_BEEF, 1'b0, "rfirst_new");

    // Misaligned and out-of-range writes are dropped.
    wr(32'h22,  32'h1234_5678);
    wr(32'h400, 32'hBAD0_BAD0);
    fetch(32'h20, 32'h1000_0008, 1'b0, "wr_misaligned");
    fetch(32'h0,  32'h0022_1000, 1'b0, "wr_out_of_range");

`ifdef INSTMEM_ERR_CHECK_EN
    fetch(32'h2,        32'h0, 1'b1, "err_misaligned");
    fetch(32'h400,      32'h0, 1'b1, "err_range");
    fetch(32'hFFFF_FFFC, 32'h0, 1'b1, "err_top");
    fetch(32'h3FC,      32'h1000_00FF, 1'b0, "err_last_ok");
`else
    fetch(32'h404,       32'h0064_1000, 1'b0, "wrap_404");
    fetch(32'h2,         32'h0022_1000, 1'b0, "ignore_low");
    fetch(32'hFFFF_FFFC, 32'h1000_00FF, 1'b0, "wrap_top");
`endif

    // Mixed traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 300; n++) begin
      req_valid = 1'($urandom % 2);
      req_addr  = ($urandom % 8 == 0) ? $urandom : 32'(($urandom % DEPTH) * 4);
      rsp_ready = ($urandom % 4) != 0;
      flush     = ($urandom % 16) == 0;
      wr_en     = ($urandom % 5) == 0;
      wr_addr   = ($urandom % 8 == 0) ? $urandom : 32'(($urandom % DEPTH) * 4);
      wr_data   = $urandom;
      cyc();
    end
    req_valid = 1'b0; flush = 1'b0; wr_en = 1'b0; rsp_ready = 1'b1;
    cyc(); cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
